// File: rtl/fpu_mul_issuer.sv
// Issues one operand pair at a time to a strobe-based FP multiplier, waits for the
// product (or a timeout that yields qNaN) and hands it downstream over valid/ready.
module fpu_mul_issuer #(
  parameter int STB_HOLD = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic        mul_a_stb,
  output logic        mul_b_stb,
  input  logic [31:0] mul_z,
  input  logic        mul_z_stb,
  output logic [31:0] out_z,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        timeout_err,
  output logic [15:0] issue_count,
  output logic [1:0]  dbg_state
);
  // Handshakes: a transfer happens on a rising clk edge where valid and ready are both
  // high; the valid side holds its data stable until that edge, ready may change freely.

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUTPUT} state_t;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  state_t      state, state_nx;
  logic [3:0]  stb_cnt;
  logic [9:0]  wait_cnt;
  logic        z_prev;
  logic        run_q;
  logic        in_flight;
  logic        accept;
  logic        z_edge;
  logic        capture;
  logic        expire;

  assign in_flight = (state == ISSUE) || (state == WAIT);
  assign in_ready  = run_q && (state == IDLE);
  assign accept    = in_valid && in_ready;
  // Only a low-to-high transition counts, so a strobe left high from before acceptance
  // is ignored until it has been seen low.
  assign z_edge    = mul_z_stb && !z_prev;
  assign capture   = z_edge && in_flight;
  assign expire    = in_flight && (wait_cnt >= 10'(TIMEOUT - 1));

  assign mul_a_stb = (state == ISSUE);
  assign mul_b_stb = mul_a_stb;
  assign out_valid = (state == OUTPUT);
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = ISSUE;
      ISSUE: begin
        if (capture || expire)                state_nx = OUTPUT;
        else if (stb_cnt == 4'(STB_HOLD - 1)) state_nx = WAIT;
      end
      WAIT:    if (capture || expire) state_nx = OUTPUT;
      OUTPUT:  if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      run_q  <= 1'b0;
      z_prev <= 1'b0;
    end else begin
      state  <= state_nx;
      run_q  <= 1'b1;
      z_prev <= mul_z_stb;
    end
  end

  // Cycle counters: stb_cnt times the strobe window, wait_cnt runs from entry to ISSUE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stb_cnt  <= '0;
      wait_cnt <= '0;
    end else if (accept) begin
      stb_cnt  <= '0;
      wait_cnt <= '0;
    end else begin
      if (state == ISSUE) stb_cnt <= stb_cnt + 4'd1;
      if (in_flight)      wait_cnt <= wait_cnt + 10'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_a       <= '0;
      mul_b       <= '0;
      issue_count <= '0;
    end else if (accept) begin
      mul_a       <= in_a;
      mul_b       <= in_b;
      issue_count <= issue_count + 16'd1;
    end
  end

  // A product arriving on the timeout cycle takes priority over the qNaN fallback.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_z       <= '0;
      timeout_err <= 1'b0;
    end else if (capture) begin
      out_z <= mul_z;
    end else if (expire) begin
      out_z       <= QNAN;
      timeout_err <= 1'b1;
    end
  end

endmodule
